// File: rtl/photo_scan_array.sv
// Phototransistor scan array: sequences an analog mux across NUM_CH channels,
// captures each settled ADC reading, and publishes the darkest channel per frame.
module photo_scan_array #(
    parameter int unsigned NUM_CH  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 500000,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned THRESH  = 120,
    parameter int unsigned HYST    = 8
) (
    input  logic                         CLK100MHZ,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [DATA_W-1:0]            adc_data,
    output logic [$clog2(NUM_CH)-1:0]    mux_addr,
    output logic [$clog2(NUM_CH)-1:0]    min_addr,
    output logic [DATA_W-1:0]            min_val,
    output logic                         move_goalie,
    output logic [31:0]                  output_goalie,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic                         overrun
);

    localparam int unsigned AW = $clog2(NUM_CH);
    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam int unsigned SW = $clog2(SETTLE + 1);

    localparam logic [AW-1:0]     LAST_CH  = AW'(NUM_CH - 1);
    localparam logic [CW-1:0]     TICK_MAX = CW'(CLK_DIV - 1);
    localparam logic [SW-1:0]     SET_LAST = SW'(SETTLE - 1);
    localparam logic [DATA_W-1:0] SET_LVL  = DATA_W'(THRESH);
    localparam logic [DATA_W-1:0] REL_LVL  = DATA_W'(THRESH + HYST);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_NEXT    = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CW-1:0]       tick_cnt;
    logic [SW-1:0]       settle_cnt;
    logic [DATA_W-1:0]   sample [NUM_CH];
    logic [AW-1:0]       run_min_addr;

    logic                tick;
    logic                publish;
    logic [DATA_W-1:0]   pub_val;
    logic                goalie_next;

    // Tick counter only advances while waiting for the mux to settle
    assign tick    = (state == S_SETTLE) && (tick_cnt == TICK_MAX);
    assign publish = enable && (state == S_NEXT) && (mux_addr == LAST_CH);

    // The running minimum is held as an index into this frame's samples
    assign pub_val = sample[run_min_addr];

    always_comb begin
        goalie_next = move_goalie;
        if (pub_val < SET_LVL) begin
            goalie_next = 1'b1;
        end else if (pub_val >= REL_LVL) begin
            goalie_next = 1'b0;
        end
    end

    // State register
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; dropping enable always abandons the frame
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (tick && (settle_cnt == SET_LAST)) begin
                    state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_next = S_NEXT;
            end
            S_NEXT: begin
                state_next = S_SETTLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (!enable) begin
            state_next = S_IDLE;
        end
    end

    // Scan timing: tick divider, settle counter and mux address
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            tick_cnt   <= '0;
            settle_cnt <= '0;
            mux_addr   <= '0;
        end else if (!enable || (state == S_IDLE)) begin
            tick_cnt   <= '0;
            settle_cnt <= '0;
            mux_addr   <= '0;
        end else begin
            if (state == S_SETTLE) begin
                tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
            end else begin
                tick_cnt <= '0;
            end

            if (state == S_NEXT) begin
                settle_cnt <= '0;
            end else if (tick) begin
                settle_cnt <= settle_cnt + SW'(1);
            end

            if (state == S_NEXT) begin
                mux_addr <= (mux_addr == LAST_CH) ? '0 : mux_addr + AW'(1);
            end
        end
    end

    // Sample capture and running-minimum tracking
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sample[i] <= '0;
            end
            run_min_addr <= '0;
        end else if (enable && (state == S_CAPTURE)) begin
            sample[mux_addr] <= adc_data;
            // Strict compare so ties keep the lower channel
            if ((mux_addr == '0) || (adc_data < sample[run_min_addr])) begin
                run_min_addr <= mux_addr;
            end
        end
    end

    // Published result with valid/ready handshake and sticky overrun
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            min_addr      <= '0;
            min_val       <= '0;
            move_goalie   <= 1'b0;
            output_goalie <= '0;
            result_valid  <= 1'b0;
            overrun       <= 1'b0;
        end else if (publish) begin
            min_addr      <= run_min_addr;
            min_val       <= pub_val;
            move_goalie   <= goalie_next;
            output_goalie <= 32'({run_min_addr, goalie_next});
            result_valid  <= 1'b1;
            if (result_valid && !result_ready) begin
                overrun <= 1'b1;
            end
        end else if (result_valid && result_ready) begin
            result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_photo_scan_array.sv
// Self-checking bench for photo_scan_array: directed and random frames against
// a frame-level reference model of minimum search, hysteresis and handshake.
module tb_photo_scan_array;

    localparam int unsigned NUM_CH  = 8;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned SETTLE  = 2;
    localparam int unsigned THRESH  = 120;
    localparam int unsigned HYST    = 8;
    localparam int unsigned CH_CYC  = SETTLE * CLK_DIV + 2;
    localparam int unsigned FRAME   = NUM_CH * CH_CYC;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [7:0]        adc_data;
    logic [2:0]        mux_addr;
    logic [2:0]        min_addr;
    logic [7:0]        min_val;
    logic              move_goalie;
    logic [31:0]       output_goalie;
    logic              result_valid;
    logic              result_ready;
    logic              overrun;

    logic [7:0]        chan [NUM_CH];

    int unsigned       vectors = 0;
    int unsigned       miscompares = 0;

    logic              exp_rv;
    logic              exp_ovr;
    logic              exp_goal;
    logic [2:0]        exp_addr;
    logic [7:0]        exp_val;

    always #5 clk = ~clk;

    assign adc_data = chan[mux_addr];

    photo_scan_array #(
        .NUM_CH  (NUM_CH),
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV),
        .SETTLE  (SETTLE),
        .THRESH  (THRESH),
        .HYST    (HYST)
    ) dut (
        .CLK100MHZ     (clk),
        .reset         (reset),
        .enable        (enable),
        .adc_data      (adc_data),
        .mux_addr      (mux_addr),
        .min_addr      (min_addr),
        .min_val       (min_val),
        .move_goalie   (move_goalie),
        .output_goalie (output_goalie),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .overrun       (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame result: lowest reading, first index on ties, then hysteresis
    task automatic frame_ref();
        int unsigned best = 0;
        for (int unsigned i = 1; i < NUM_CH; i++) begin
            if (chan[i] < chan[best]) best = i;
        end
        exp_addr = 3'(best);
        exp_val  = chan[best];
        if (int'(exp_val) < int'(THRESH)) exp_goal = 1'b1;
        else if (int'(exp_val) >= int'(THRESH + HYST)) exp_goal = 1'b0;
    endtask

    // One clock: apply ready, advance model, compare every output
    task automatic step(input logic rdy, input bit pub, input int unsigned exp_mux);
        result_ready = rdy;
        @(posedge clk);
        #1;
        if (reset) begin
            exp_rv = 1'b0; exp_ovr = 1'b0; exp_goal = 1'b0;
            exp_addr = '0; exp_val = '0;
        end else if (pub) begin
            frame_ref();
            if (exp_rv && !rdy) exp_ovr = 1'b1;
            exp_rv = 1'b1;
        end else if (exp_rv && rdy) begin
            exp_rv = 1'b0;
        end
        chk("mux_addr", 32'(mux_addr), 32'(exp_mux));
        chk("result_valid", 32'(result_valid), 32'(exp_rv));
        chk("overrun", 32'(overrun), 32'(exp_ovr));
        chk("min_addr", 32'(min_addr), 32'(exp_addr));
        chk("min_val", 32'(min_val), 32'(exp_val));
        chk("move_goalie", 32'(move_goalie), 32'(exp_goal));
        chk("output_goalie", output_goalie, (32'(exp_addr) << 1) | 32'(exp_goal));
    endtask

    // mode 0: ready low; 1: ready only in publish cycle; 2: random ready
    task automatic run_steps(input int unsigned mode, input int unsigned last);
        logic rdy;
        for (int unsigned c = 1; c <= last; c++) begin
            case (mode)
                0:       rdy = 1'b0;
                1:       rdy = (c == FRAME);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            step(rdy, c == FRAME, (c / CH_CYC) % NUM_CH);
        end
    endtask

    task automatic fill(input logic [7:0] base, input int unsigned idx, input logic [7:0] v);
        for (int unsigned i = 0; i < NUM_CH; i++) chan[i] = base;
        chan[idx] = v;
    endtask

    task automatic fill_rand(input int unsigned lo, input int unsigned hi);
        for (int unsigned i = 0; i < NUM_CH; i++) chan[i] = 8'($urandom_range(lo, hi));
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        result_ready = 1'b1;
        fill(8'd0, 0, 8'd0);
        exp_rv = 1'b0; exp_ovr = 1'b0; exp_goal = 1'b0;
        exp_addr = '0; exp_val = '0;

        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        reset = 1'b0;
        enable = 1'b0;
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);

        // Basic frame with ready held low
        chan[0] = 8'd200; chan[1] = 8'd180; chan[2] = 8'd90;  chan[3] = 8'd150;
        chan[4] = 8'd200; chan[5] = 8'd200; chan[6] = 8'd200; chan[7] = 8'd200;
        enable = 1'b1;
        step(1'b0, 1'b0, 0);
        run_steps(0, FRAME);
        chk("basic_min_addr", 32'(min_addr), 32'd2);
        chk("basic_min_val", 32'(min_val), 32'd90);
        chk("basic_goalie", 32'(move_goalie), 32'd1);
        chk("basic_word", output_goalie, 32'h5);
        chk("basic_valid", 32'(result_valid), 32'd1);

        // Hysteresis sequence, accepted in the publish cycle each time
        fill(8'd200, 1, 8'd119);
        run_steps(1, FRAME);
        chk("hyst119", 32'(move_goalie), 32'd1);
        fill(8'd200, 4, 8'd125);
        run_steps(1, FRAME);
        chk("hyst125", 32'(move_goalie), 32'd1);
        fill(8'd200, 7, 8'd128);
        run_steps(1, FRAME);
        chk("hyst128", 32'(move_goalie), 32'd0);
        chk("pulse_valid", 32'(result_valid), 32'd1);
        chk("pulse_overrun", 32'(overrun), 32'd0);

        // Tie at channels 3 and 6, published over an unaccepted result
        fill(8'd100, 3, 8'd50);
        chan[6] = 8'd50;
        run_steps(0, FRAME);
        chk("tie_addr", 32'(min_addr), 32'd3);
        chk("overrun_set", 32'(overrun), 32'd1);

        // Random frames, some in a narrow band to force ties and hysteresis
        for (int unsigned f = 0; f < 8; f++) begin
            if (f[0]) fill_rand(112, 132);
            else      fill_rand(0, 255);
            run_steps(2, FRAME);
        end

        // Enable dropped mid-frame at channel 5
        fill_rand(0, 255);
        run_steps(2, 5 * CH_CYC + 3);
        enable = 1'b0;
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        enable = 1'b1;
        step(1'b0, 1'b0, 0);
        fill_rand(0, 255);
        run_steps(2, FRAME);

        // Reset mid-frame beats enable and ready
        fill_rand(0, 255);
        run_steps(2, 3 * CH_CYC + 4);
        reset = 1'b1;
        step(1'b1, 1'b0, 0);
        chk("rst_word", output_goalie, 32'h0);
        reset = 1'b0;
        step(1'b0, 1'b0, 0);
        fill_rand(0, 255);
        run_steps(0, FRAME);
        chk("post_rst_valid", 32'(result_valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
